// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit: the instruction-memory request/response pair and the
// valid/ready instruction stream to decode. The master modport is the fetch unit's side.
interface fetch_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_gnt, mem_rvalid, mem_rdata, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps up to DEPTH requests in flight and buffers
// in-order responses for decode. Define FETCH_PERF_CNT_EN to build the decode-starved stall counter.
module fetch_unit #(
  parameter int              DATA_W   = 16,
  parameter int              ADDR_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              PC_INC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      bus,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [31:0]       stall_cnt,
  output logic              err
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W:0]    DEPTH_L     = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE     = PTR_W'(1);
  localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(PC_INC);
  localparam bit                PC_INC_EVEN = (PC_INC % 2) == 0;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  discard;
  logic              halted;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  tag_ptr;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [ADDR_W-1:0] tag_mem  [DEPTH];

  logic              issue;
  logic              resp;
  logic              resp_keep;
  logic              pop;
  logic              buf_valid;
  logic [CNT_W:0]    in_use;

  // Everything that can occupy a buffer slot, including words still in flight.
  assign in_use    = {1'b0, count} + {1'b0, outstanding};
  assign buf_valid = (count != '0);

  assign bus.mem_req    = !rst && !halted && !halt && !redirect && (in_use < DEPTH_L);
  assign bus.mem_addr   = fetch_pc;
  assign bus.inst_valid = buf_valid;
  assign bus.inst       = buf_valid ? data_mem[rd_ptr] : '0;
  assign bus.inst_pc    = buf_valid ? tag_mem[rd_ptr]  : '0;

  // A response with nothing in flight is spurious: flagged in err and never buffered.
  assign issue     = bus.mem_req && bus.mem_gnt;
  assign resp      = bus.mem_rvalid && (outstanding != '0);
  assign resp_keep = resp && (discard == '0);
  assign pop       = buf_valid && bus.inst_ready;

  // NOTE: state updates use non-blocking assignments so every register in this block
  // samples the same pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      halted      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_ptr     <= '0;
    end else if (redirect) begin
      // Whatever is still in flight after this cycle belongs to the old path.
      fetch_pc    <= redirect_pc;
      count       <= '0;
      outstanding <= outstanding - CNT_W'(resp);
      discard     <= outstanding - CNT_W'(resp);
      halted      <= halt;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      tag_ptr     <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + PC_STEP;
        tag_ptr  <= tag_ptr + PTR_ONE;
      end
      if (resp && (discard != '0)) discard <= discard - CNT_ONE;
      if (resp_keep)               wr_ptr  <= wr_ptr + PTR_ONE;
      if (pop)                     rd_ptr  <= rd_ptr + PTR_ONE;
      if (halt)                    halted  <= 1'b1;
      outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
      count       <= count + CNT_W'(resp_keep) - CNT_W'(pop);
    end
  end

  // NOTE: the buffer arrays have no reset; count gates every read, so stale slots are never seen.
  always_ff @(posedge clk) begin
    if (issue)                           tag_mem[tag_ptr] <= fetch_pc;
    if (resp_keep && !rst && !redirect)  data_mem[wr_ptr] <= bus.mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((redirect && PC_INC_EVEN && redirect_pc[0]) ||
                 (bus.mem_rvalid && (outstanding == '0))) begin
      err <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.inst_ready && !buf_valid && !halted && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = 32'h0;
`endif

endmodule
